// File: rtl/mode_scheduler_pkg.sv
// Shared definitions for the watch mode scheduler.
// Holds the mode and state encodings, the LCD frame length, and the dip_sw decode.
package mode_scheduler_pkg;

    localparam logic [1:0] MODE_WATCH = 2'd0;
    localparam logic [1:0] MODE_SET   = 2'd1;
    localparam logic [1:0] MODE_ALARM = 2'd2;
    localparam logic [1:0] MODE_STOP  = 2'd3;

    // index_char of the last character in an LCD frame
    localparam int unsigned LCD_LAST_INDEX = 31;

    typedef enum logic [1:0] {
        StRun,
        StPending,
        StMask,
        StAlarm
    } state_e;

    // Only a single recognised switch selects a non-watch mode; anything else is watch.
    function automatic logic [1:0] decode_req(input logic [3:0] sw);
        logic [1:0] m;
        case (sw)
            4'b0001: m = MODE_SET;
            4'b0010: m = MODE_ALARM;
            4'b0100: m = MODE_STOP;
            default: m = MODE_WATCH;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mode_sync_decode.sv
// Two-flop synchroniser for the raw dip_sw inputs followed by decode to a requested mode.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   dip_sw   : raw mode-select switches
//   req      : requested mode decoded from the synchronised switches
module mode_sync_decode
    import mode_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dip_sw,
    output logic [1:0] req
);

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= dip_sw;
            sync2_q <= sync1_q;
        end
    end

    assign req = decode_req(sync2_q);

endmodule

// File: rtl/mode_scheduler.sv
// Decides which watch mode owns the LCD character stream and the push-switches.
// Mode changes commit only at an LCD frame end, switches are masked across a change until
// released, and a rising alarm_req pre-empts the display until acknowledged or timed out.
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   dip_sw                  : raw mode-select switches
//   sw_in                   : debounced push-switch levels
//   en_1hz                  : one-cycle 1 Hz enable (alarm timeout tick)
//   en_clk, index_char      : LCD driver step enable and character index
//   alarm_req               : alarm-match level
//   data_mode0..data_mode3  : character from each mode
//   data_char               : character to the LCD driver
//   sw_mode0..sw_mode3      : switch levels routed to each mode
//   mode                    : committed mode
//   alarm_active, mode_busy : status (ALARM; PENDING or MASK)
module mode_scheduler
    import mode_scheduler_pkg::*;
#(
    parameter int unsigned LAST_INDEX    = LCD_LAST_INDEX,
    parameter int unsigned ALARM_TIMEOUT = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dip_sw,
    input  logic [3:0] sw_in,
    input  logic       en_1hz,
    input  logic       en_clk,
    input  logic [4:0] index_char,
    input  logic       alarm_req,
    input  logic [7:0] data_mode0,
    input  logic [7:0] data_mode1,
    input  logic [7:0] data_mode2,
    input  logic [7:0] data_mode3,
    output logic [7:0] data_char,
    output logic [3:0] sw_mode0,
    output logic [3:0] sw_mode1,
    output logic [3:0] sw_mode2,
    output logic [3:0] sw_mode3,
    output logic [1:0] mode,
    output logic       alarm_active,
    output logic       mode_busy
);

    localparam int unsigned CntW = $clog2(ALARM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(ALARM_TIMEOUT);

    logic [1:0]      req;
    state_e          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            alarm_req_q;
    logic            alarm_rise;
    logic            frame_end;

    mode_sync_decode u_sync_decode (
        .clk    (clk),
        .rst    (rst),
        .dip_sw (dip_sw),
        .req    (req)
    );

    assign alarm_rise = alarm_req & ~alarm_req_q;
    assign frame_end  = en_clk && (index_char == 5'(LAST_INDEX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            mode_q      <= MODE_WATCH;
            cnt_q       <= '0;
            alarm_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            alarm_req_q <= alarm_req;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        if (alarm_rise && (state_q != StAlarm)) begin
            state_d = StAlarm;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (req != mode_q) state_d = StPending;
                end
                StPending: begin
                    if (req == mode_q) begin
                        state_d = StRun;
                    end else if (frame_end) begin
                        mode_d  = req;
                        state_d = StMask;
                    end
                end
                StMask: begin
                    if (sw_in == 4'b0000) state_d = StRun;
                end
                StAlarm: begin
                    if (en_1hz && (cnt_q != CntMax)) cnt_d = cnt_q + CntW'(1);
                    // Acknowledge and timeout leave through the same path.
                    if ((|sw_in) || (cnt_d == CntMax)) begin
                        state_d = (req != mode_q) ? StPending : StMask;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        data_char    = data_mode0;
        sw_mode0     = 4'b0000;
        sw_mode1     = 4'b0000;
        sw_mode2     = 4'b0000;
        sw_mode3     = 4'b0000;
        alarm_active = (state_q == StAlarm);
        mode_busy    = (state_q == StPending) || (state_q == StMask);
        mode         = mode_q;

        if (state_q == StAlarm) begin
            data_char = data_mode2;
        end else begin
            case (mode_q)
                MODE_WATCH: data_char = data_mode0;
                MODE_SET:   data_char = data_mode1;
                MODE_ALARM: data_char = data_mode2;
                MODE_STOP:  data_char = data_mode3;
                default:    data_char = data_mode0;
            endcase
        end

        if (state_q == StRun) begin
            case (mode_q)
                MODE_WATCH: sw_mode0 = sw_in;
                MODE_SET:   sw_mode1 = sw_in;
                MODE_ALARM: sw_mode2 = sw_in;
                MODE_STOP:  sw_mode3 = sw_in;
                default:    sw_mode0 = sw_in;
            endcase
        end
    end

endmodule

// File: doc/mode_scheduler.md
Name: mode_scheduler

Overview:
- Central controller that decides which watch mode (0 watch, 1 time-set, 2 alarm, 3 stopwatch) owns the LCD character stream and the debounced push-switches.
- Replaces the combinational dip_sw case-mux in digital_clock.
- Synchronises dip_sw and commits mode changes only at an LCD frame boundary, so no frame is torn.
- Masks switches across a mode change until they are released, and lets a ringing alarm pre-empt the display with acknowledge/timeout.

Parameters:
LAST_INDEX, 31, index_char value of the final character of an LCD frame.
ALARM_TIMEOUT, 60, number of en_1hz pulses after which an unacknowledged alarm auto-exits.

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-low (driven by rstn as for all sub-blocks)
dip_sw  in  4  raw mode-select switches
sw_in  in  4  debounced push-switch levels (sw_out of debouncers)
en_1hz  in  1  1-cycle 1 Hz enable
en_clk  in  1  LCD driver step enable
index_char  in  5  LCD driver character index
alarm_req  in  1  alarm-match level from mode_watch
data_mode0..data_mode3  in  8 each  character from each mode
data_char  out  8  character to lcd_driver
sw_mode0..sw_mode3  out  4 each  switch levels routed to each mode
mode  out  2  committed mode
alarm_active  out  1  high while in ALARM
mode_busy  out  1  high in PENDING or MASK

Behaviour:
- Reset (rst=0, async): state RUN, mode=0, sync flops=0, alarm_req edge flop=0, timeout counter=0. alarm_active=0, mode_busy=0, all sw_modeN=0, data_char=data_mode0.
- dip_sw passes a 2-flop synchroniser; req decoded from the synced value: 0001->1, 0010->2, 0100->3, anything else->0.
- data_char = data_modeN for N = mode (combinational mux). In ALARM, data_char = data_mode2.
- Switch routing:
  - sw_modeN = sw_in only when state=RUN and N=mode; otherwise 4'b0.
  - All sw_modeN = 0 in PENDING, MASK and ALARM.
- State transitions (evaluated in priority order each cycle):
  - ALARM entry: a rising edge of alarm_req (registered compare, 1-cycle detect) from any state -> ALARM next cycle; counter cleared. A rising edge while already in ALARM is ignored and does not restart the counter.
  - RUN: req != mode -> PENDING.
  - PENDING: req == mode -> RUN (request withdrawn). Otherwise, on a cycle with en_clk=1 and index_char==LAST_INDEX -> mode<=req, state MASK in the same edge. A req change while in PENDING retargets silently; the latest req is committed.
  - MASK: sw_in==4'b0000 -> RUN. A switch held through the change is never seen by the new mode.
  - ALARM:
    - Counter increments on en_1hz.
    - Exit occurs on any sw_in bit high (acknowledge) or when counter reaches ALARM_TIMEOUT; acknowledge wins if both occur in the same cycle.
    - On exit: if req != mode -> PENDING; else -> MASK.
    - Counter width = $clog2(ALARM_TIMEOUT+1); it saturates and never wraps.
- mode changes only on the PENDING->MASK edge; there is no other path.
- Latency: dip_sw toggle -> PENDING = 3 cycles (2 sync + 1); commit waits for the next frame end (at most one LCD frame).
- Reset mid-PENDING or mid-ALARM returns to mode 0 / RUN immediately (asynchronous).

Decomposition:
- Shared package holds:
  - mode encodings MODE_WATCH=0, MODE_SET=1, MODE_ALARM=2, MODE_STOP=3;
  - state encodings RUN, PENDING, MASK, ALARM;
  - LCD_LAST_INDEX=31.
- One natural sub-module: mode_sync_decode (2-flop synchroniser plus one-hot decode to req). FSM, counter and muxes stay in mode_scheduler.

Test Plan:
- Reset with dip_sw=0001 held -> mode=0, data_char=data_mode0, all sw_mode=0. After release, 3 cycles -> PENDING; at first en_clk && index_char=31 -> mode=1, MASK; sw_in=0 -> RUN, sw_mode1 follows sw_in=0010.
- In mode 1 hold sw_in=0001 while dip_sw->0100 -> mode=3 at frame end, sw_mode3 stays 0 until sw_in=0, then RUN.
- dip_sw 0000->0010->0000 within one frame -> PENDING then RUN; mode never leaves 0 and data_char is never data_mode2.
- alarm_req rises in mode 3 -> ALARM next cycle, alarm_active=1, data_char=data_mode2. sw_in=1000 -> exit to MASK, mode=3, alarm_active=0.
- alarm_req rises, no switches, 60 en_1hz pulses -> exit on the 60th pulse; a second alarm_req edge at pulse 30 has no effect.
- Assert rst low during PENDING (dip_sw=0100) -> immediate mode=0, RUN. After release, a fresh PENDING occurs and mode=3 at the next frame end.
